// File: rtl/alu_arbiter_pkg.sv
// Shared types and widths for the ALU sharing arbiter.
// Operand/result widths, ALU opcodes, controller FSM states.
// Also holds the 8-bit saturating increment used by the optional grant statistics.
package alu_pkg;

  localparam int A_W = 4;
  localparam int C_W = 5;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_INV = 2'b10,
    OP_3   = 2'b11
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ISSUE   = 2'b01,
    CAPTURE = 2'b10,
    RESP    = 2'b11
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester and response channels between client blocks and the ALU arbiter.
// master = client side (drives requests, consumes responses); slave = arbiter side.
// Requests use per-requester valid with one-hot ready; responses use valid/ready.
interface alu_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0]              req_ready;
  logic [NUM_REQ*alu_pkg::A_W-1:0] req_a;
  logic [NUM_REQ*alu_pkg::A_W-1:0] req_b;
  logic [NUM_REQ*2-1:0]            req_op;
  logic                            resp_valid;
  logic                            resp_ready;
  logic [ID_W-1:0]                 resp_id;
  logic [alu_pkg::C_W-1:0]         resp_c;

  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_c
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready,
    output req_ready, resp_valid, resp_id, resp_c
  );

endinterface

// File: rtl/alu_arbiter_rr_grant.sv
// Round-robin picker: first asserted request strictly after last, wrapping.
// Latency: purely combinational.
// No backpressure; the caller decides whether the pick is taken.
module rr_grant #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int cand;

  // Scan from farthest to nearest offset so the nearest hit after 'last' wins.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int off = N; off >= 1; off--) begin
      cand = int'(last) + off;
      if (cand >= N) cand = cand - N;
      if (req[IW'(cand)]) begin
        idx = IW'(cand);
        any = 1'b1;
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered 4-bit signed ALU among NUM_REQ requesters, round-robin.
// Latency: accept in cycle 0, tagged response valid in cycle 3; one op in flight.
// Backpressure: resp_ready low holds the response and blocks new grants.
// Optional ALU_ARB_STATS_EN adds per-requester saturating grant counters.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                clock,
  input  logic                reset_n,
  alu_arbiter_if.slave        bus,
  output logic [A_W-1:0]      alu_a,
  output logic [A_W-1:0]      alu_b,
  output logic [1:0]          alu_opcode,
  output logic                alu_reset,
  input  logic [C_W-1:0]      alu_c
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NUM_REQ*8-1:0] grant_count
`endif
);

  state_t              state, state_nxt;
  logic [ID_W-1:0]     last_grant;
  logic [ID_W-1:0]     pick_idx;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic                pick_any;
  logic                grant;
  logic [A_W-1:0]      opa_q, opb_q;
  opcode_t             op_q;
  logic [ID_W-1:0]     resp_id_q;
  logic [C_W-1:0]      resp_c_q;

  rr_grant #(.N(NUM_REQ), .IW(ID_W)) u_rr_grant (
    .req  (bus.req_valid),
    .last (last_grant),
    .gnt  (pick_onehot),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state, grant strobe and response valid; both strobes are masked while reset is held.
  always_comb begin
    state_nxt      = state;
    grant          = 1'b0;
    bus.req_ready  = '0;
    bus.resp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any && reset_n) begin
          grant         = 1'b1;
          bus.req_ready = pick_onehot;
          state_nxt     = ISSUE;
        end
      end
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP: begin
        bus.resp_valid = reset_n;
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture on grant, result/tag capture one cycle after the ALU registers it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      last_grant <= ID_W'(NUM_REQ - 1);
      opa_q      <= '0;
      opb_q      <= '0;
      op_q       <= OP_ADD;
      resp_id_q  <= '0;
      resp_c_q   <= '0;
    end else begin
      if (grant) begin
        last_grant <= pick_idx;
        opa_q      <= bus.req_a[int'(pick_idx)*A_W +: A_W];
        opb_q      <= bus.req_b[int'(pick_idx)*A_W +: A_W];
        op_q       <= opcode_t'(bus.req_op[int'(pick_idx)*2 +: 2]);
      end
      if (state == CAPTURE) begin
        resp_c_q  <= alu_c;
        resp_id_q <= last_grant;
      end
    end
  end

  // ALU reset trails our own reset by one cycle and is never itself reset.
  always_ff @(posedge clock) begin
    alu_reset <= ~reset_n;
  end

  assign alu_a       = opa_q;
  assign alu_b       = opb_q;
  assign alu_opcode  = op_q;
  assign bus.resp_id = resp_id_q;
  assign bus.resp_c  = resp_c_q;

`ifdef ALU_ARB_STATS_EN
  logic [7:0] cnt_q [NUM_REQ];

  // One saturating grant counter per requester.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (grant) begin
      cnt_q[pick_idx] <= sat_inc8(cnt_q[pick_idx]);
    end
  end

  // Flatten counters onto the output bus, requester i at [8i+7:8i].
  always_comb begin
    grant_count = '0;
    for (int i = 0; i < NUM_REQ; i++) grant_count[i*8 +: 8] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural registered ALU.
// Expected values are hand-computed constants.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic           clock;
  logic           reset_n;
  logic [A_W-1:0] alu_a, alu_b;
  logic [1:0]     alu_opcode;
  logic           alu_reset;
  logic [C_W-1:0] alu_c;
`ifdef ALU_ARB_STATS_EN
  logic [NUM_REQ*8-1:0] grant_count;
`endif

  int checks = 0;
  int errors = 0;

  alu_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  alu_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_reset  (alu_reset),
    .alu_c      (alu_c)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_count(grant_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Registered 4-bit signed ALU with 5-bit result.
  always @(posedge clock) begin
    if (alu_reset) alu_c <= '0;
    else begin
      case (alu_opcode)
        2'b00:   alu_c <= {alu_a[3], alu_a} + {alu_b[3], alu_b};
        2'b01:   alu_c <= {alu_a[3], alu_a} - {alu_b[3], alu_b};
        2'b10:   alu_c <= ~{alu_a[3], alu_a};
        default: alu_c <= '0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    bus.req_a[i*4 +: 4]  = a;
    bus.req_b[i*4 +: 4]  = b;
    bus.req_op[i*2 +: 2] = op;
  endtask

  // Called in an IDLE cycle with requests already driven and resp_ready high.
  task automatic serve(input string tag, input int id, input logic [4:0] c, input bit drop);
    #1;
    check({tag, "_grant"}, bus.req_ready, 32'(1 << id));
    tick();
    if (drop) bus.req_valid[id] = 1'b0;
    check({tag, "_c1_valid"}, bus.resp_valid, 0);
    check({tag, "_c1_ready"}, bus.req_ready, 0);
    tick();
    check({tag, "_c2_valid"}, bus.resp_valid, 0);
    tick();
    check({tag, "_c3_valid"}, bus.resp_valid, 1);
    check({tag, "_c3_id"}, bus.resp_id, id);
    check({tag, "_c3_c"}, bus.resp_c, c);
    tick();
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.req_valid  = 4'hF;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_op     = '0;
    bus.resp_ready = 1'b1;
    set_req(0, 4'd1, 4'd0, OP_ADD);
    set_req(1, 4'd2, 4'd1, OP_ADD);
    set_req(2, 4'd3, 4'd2, OP_ADD);
    set_req(3, 4'b0100, 4'b1101, OP_SUB);

    // Reset held two cycles with every requester valid.
    tick();
    tick();
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_alu_reset", alu_reset, 1);
    check("rst_resp_c", bus.resp_c, 0);
    check("rst_resp_id", bus.resp_id, 0);
    check("rst_alu_a", alu_a, 0);

    // Requester 0 wins first after release.
    reset_n = 1'b1;
    serve("first", 0, 5'd1, 1'b1);

    // Single add: 6 + (-5) = 1.
    bus.req_valid = 4'b0100;
    set_req(2, 4'b0110, 4'b1011, OP_ADD);
    serve("add", 2, 5'b00001, 1'b1);

    // Subtract to -15.
    bus.req_valid = 4'b0010;
    set_req(1, 4'b1000, 4'b0111, OP_SUB);
    serve("sub", 1, 5'b10001, 1'b1);

    // -8 + -8 = -16.
    bus.req_valid = 4'b1000;
    set_req(3, 4'b1000, 4'b1000, OP_ADD);
    serve("addneg", 3, 5'b10000, 1'b1);

    // Fairness: all valids held high across eight requests.
    set_req(0, 4'd1, 4'd0, OP_ADD);
    set_req(1, 4'd2, 4'd1, OP_ADD);
    set_req(2, 4'd3, 4'd2, OP_ADD);
    set_req(3, 4'b0100, 4'b1101, OP_SUB);
    bus.req_valid = 4'hF;
    for (int r = 0; r < 2; r++) begin
      serve("rr0", 0, 5'd1, 1'b0);
      serve("rr1", 1, 5'd3, 1'b0);
      serve("rr2", 2, 5'd5, 1'b0);
      serve("rr3", 3, 5'd7, 1'b0);
    end
    bus.req_valid = 4'h0;

    // Backpressure: hold the response for 10 cycles with another request pending.
    bus.resp_ready = 1'b0;
    set_req(0, 4'b0011, 4'b0010, OP_ADD);
    set_req(1, 4'd1, 4'd1, OP_ADD);
    bus.req_valid = 4'b0001;
    #1;
    check("bp_grant", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = 4'b0010;
    tick();
    tick();
    for (int k = 0; k < 10; k++) begin
      check("bp_hold", {bus.resp_valid, bus.resp_id, bus.resp_c, bus.req_ready},
            {1'b1, 2'd0, 5'd5, 4'b0000});
      tick();
    end
    bus.resp_ready = 1'b1;
    #1;
    check("bp_hs_valid", bus.resp_valid, 1);
    check("bp_hs_ready", bus.req_ready, 0);
    tick();
    serve("bp_next", 1, 5'd2, 1'b1);

    // Reset asserted while in CAPTURE discards the operation.
    set_req(2, 4'd1, 4'd1, OP_ADD);
    bus.req_valid = 4'b0100;
    #1;
    check("mid_grant", bus.req_ready, 4'b0100);
    tick();
    bus.req_valid = 4'h0;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mid_alu_reset", alu_reset, 1);
    check("mid_resp_c", bus.resp_c, 0);
`ifdef ALU_ARB_STATS_EN
    check("stats_clear", grant_count, 0);
`endif
    for (int k = 0; k < 6; k++) begin
      check("mid_no_resp", bus.resp_valid, 0);
      tick();
    end

    // Round-robin pointer is back at its reset value.
    bus.req_valid = 4'hF;
    serve("post_rst", 0, 5'd5, 1'b0);
    bus.req_valid = 4'h0;

`ifdef ALU_ARB_STATS_EN
    // 300 further grants to requester 0 saturate its counter.
    bus.req_valid = 4'b0001;
    repeat (1200) tick();
    bus.req_valid = 4'h0;
    repeat (4) tick();
    check("stats_sat", grant_count, 32'h0000_00FF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencing controller that shares a single registered 4-bit signed ALU among `NUM_REQ` requesters. Requesters present operand/opcode requests on a valid/ready handshake. A round-robin arbiter grants one request at a time and drives it into the ALU. The 5-bit result is captured and returned on a tagged response channel. The block sits between client blocks and the ALU instance and owns the ALU's reset.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `ID_W`, `$clog2(NUM_REQ)`, response tag width
- `clock`  in  1  single clock; all state updates on rising edge
- `reset_n`  in  1  reset, synchronous, active-low
- `req_valid`  in  NUM_REQ  per-requester request valid
- `req_ready`  out  NUM_REQ  one-hot grant/accept strobe
- `req_a`  in  NUM_REQ*4  signed operand A, requester i at [4i+3:4i]
- `req_b`  in  NUM_REQ*4  signed operand B, same packing
- `req_op`  in  NUM_REQ*2  opcode, requester i at [2i+1:2i]
- `alu_a`, `alu_b`  out  4  operands to ALU
- `alu_opcode`  out  2  opcode to ALU
- `alu_reset`  out  1  active-high reset to ALU, equals ~reset_n registered
- `alu_c`  in  5  registered ALU result
- `resp_valid`  out  1  response valid
- `resp_ready`  in  1  response consumer ready
- `resp_id`  out  ID_W  index of requester owning the response
- `resp_c`  out  5  result, alu_c verbatim

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE: if any req_valid, grant g = first valid index after `last_grant` (wrapping). Assert req_ready[g] combinationally this cycle only. Latch req_a/b/op[g] into operand registers. Set last_grant=g. Go to ISSUE. Otherwise stay in IDLE.
- ISSUE: operand registers drive alu_a/alu_b/alu_opcode, which the ALU registers at the end of this cycle. Go to CAPTURE.
- CAPTURE: latch alu_c into resp_c and g into resp_id. Go to RESP.
- RESP: resp_valid=1. resp_c and resp_id are held stable until resp_valid&resp_ready. On that handshake, go to IDLE. No grant is made in the handshake cycle.
- Requesters hold valid and operands stable until their ready. Dropping valid before ready is legal; no grant occurs for that requester.
- Arbiter performs no arithmetic; result width/sign are defined by the ALU (5-bit two's complement).
- alu_a/b/opcode hold their last value outside ISSUE; they are 0 after reset.

## Timing
- Reset (reset_n low at an edge): state=IDLE, last_grant=NUM_REQ-1 (requester 0 wins first), operand regs=0, resp_valid=0, resp_id=0, resp_c=0, req_ready=0, alu_reset=1 the following cycle.
- Reset mid-operation discards the in-flight op; no response is produced.
- Latency: accept edge (cycle 0) → resp_valid high in cycle 3.
- Minimum issue interval is 4 cycles per request with resp_ready held high.
- Simultaneous valids are served in strict rotation. A continuously asserting requester waits at most NUM_REQ-1 grants.
- resp_ready low stalls the FSM in RESP indefinitely. Responses are never dropped or overwritten.

## Configuration
- `ALU_ARB_STATS_EN` defined: adds output `grant_count` (NUM_REQ*8). It holds one 8-bit saturating counter per requester, incremented on each grant, cleared by reset, and holding at 255.
- Macro undefined: port and counters are absent; behaviour is otherwise identical.

## Structure
- Package `alu_pkg`:
  - `A_W`=4, `C_W`=5;
  - opcode enum (OP_ADD=2'b00, OP_SUB=2'b01, OP_INV=2'b10, OP_3=2'b11);
  - FSM state enum.
- Sub-module `rr_grant`: combinational round-robin picker (inputs req vector, last_grant; outputs one-hot grant and index). It is instantiated once.

## Test plan
- Reset: hold reset_n=0 for 2 cycles with all req_valid=1 → req_ready=0, resp_valid=0, alu_reset=1. After release, requester 0 is granted first.
- Single add: req 2 with A=4'b0110, B=4'b1011, OP_ADD, resp_ready=1 → resp_valid in cycle 3, resp_id=2, resp_c=5'b00001.
- Sub overflow range: A=4'b1000, B=4'b0111, OP_SUB → resp_c=5'b10001 (-15). Also A=B=4'b1000, OP_ADD → 5'b10000.
- Fairness: all 4 valids held high for 8 requests → grant order 0,1,2,3,0,1,2,3, and each resp_id matches its operands.
- Backpressure: resp_ready=0 for 10 cycles during RESP → resp_valid/resp_c/resp_id stable, no req_ready pulses. Release → handshake, next grant one cycle after return to IDLE.
- Mid-op reset: reset_n low in CAPTURE → no response emitted. With `ALU_ARB_STATS_EN`, grant_count clears to 0 and saturates at 255 after 300 grants to one requester.
